rcadder: RTL and testbench



---
 rtl/rcadder_pkg.sv | 16 +
 rtl/rcadder_full_adder.sv | 16 +
 rtl/rcadder.sv | 59 +++++
 tb/tb_rcadder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rcadder_pkg.sv
// Shared constants and reference arithmetic for the ripple-carry adder.
package rcadder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 64;

    // Plain-arithmetic reference, sized for the widest legal adder; callers slice what they need.
    function automatic logic [MAX_WIDTH:0] ref_add(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/rcadder_full_adder.sv
// One-bit combinational full adder, the cell of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rcadder.sv
// Ripple-carry adder with registered sum/carry-out, one cycle latency.
// Optional carry-in port enabled by defining RCADDER_CIN_EN.
module rcadder
    import rcadder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef RCADDER_CIN_EN
    input  logic             cin,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

`ifdef RCADDER_CIN_EN
    assign c[0] = cin;
`else
    assign c[0] = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_comb begin
        sum_d  = s;
        cout_d = c[WIDTH];
    end

    // Reset wins over the operands, so an in-flight result is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_rcadder.sv
// Directed + exhaustive self-checking bench for rcadder (WIDTH = 8).
module tb_rcadder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
`ifdef RCADDER_CIN_EN
    logic         cin;
`endif
    logic [W-1:0] sum;
    logic         cout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rcadder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
`ifdef RCADDER_CIN_EN
        .cin  (cin),
`endif
        .sum  (sum),
        .cout (cout)
    );

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got={cout,sum}=%h expected=%h", tag, got, exp);
    endtask

    // Advance one edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av;
        b = bv;
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
`ifdef RCADDER_CIN_EN
        cin = 1'b0;
`endif
        #1;

        // Reset holds outputs at zero even with a carrying operand pair present.
        drive(8'hFF, 8'h01);
        step();
        chk("reset_c1", {cout, sum}, 9'h000);
        step();
        chk("reset_c2", {cout, sum}, 9'h000);
        rst = 1'b0;
        step();
        chk("post_reset", {cout, sum}, 9'h100);

        // Basic add, exactly one cycle latency.
        drive(8'd3, 8'd5);
        step();
        chk("add_3_5", {cout, sum}, 9'd8);

        drive(8'hFF, 8'h01);
        step();
        chk("ripple_ff_01", {cout, sum}, 9'h100);
        drive(8'hFF, 8'hFF);
        step();
        chk("ripple_ff_ff", {cout, sum}, 9'h1FE);
        drive(8'hAA, 8'h55);
        step();
        chk("alt_aa_55", {cout, sum}, 9'h0FF);

        // Streaming: one result per cycle.
        drive(8'd1, 8'd1);
        step();
        chk("stream_1_1", {cout, sum}, 9'h002);
        drive(8'd128, 8'd128);
        step();
        chk("stream_128_128", {cout, sum}, 9'h100);
        drive(8'd0, 8'd0);
        step();
        chk("stream_0_0", {cout, sum}, 9'h000);

        // Reset mid-stream discards the captured pair.
        drive(8'hF0, 8'h20);
        rst = 1'b1;
        step();
        chk("mid_reset", {cout, sum}, 9'h000);
        rst = 1'b0;
        step();
        chk("after_mid_reset", {cout, sum}, 9'h110);

`ifdef RCADDER_CIN_EN
        drive(8'hFF, 8'h00);
        cin = 1'b1;
        step();
        chk("cin1_ff_00", {cout, sum}, 9'h100);
        cin = 1'b0;
        step();
        chk("cin0_ff_00", {cout, sum}, 9'h0FF);
        drive(8'hFF, 8'hFF);
        cin = 1'b1;
        step();
        chk("cin1_ff_ff", {cout, sum}, 9'h1FF);
        cin = 1'b0;
`endif

        // Exhaustive sweep against plain arithmetic.
        for (int i = 0; i < 65536; i++) begin
            logic [W-1:0] av, bv;
            av = W'(i >> 8);
            bv = W'(i);
            drive(av, bv);
            step();
            chk("exhaustive", {cout, sum}, {1'b0, av} + {1'b0, bv});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
